// File: rtl/merge_tree_param.sv
// merge_tree_param: L-leaf binary merge tree that merges ascending-sorted leaf
// streams into one ascending stream, one item per cycle. Nodes are numbered in
// heap order: node 1 is the root, node n has children 2n and 2n+1, and leaf k
// is node L+k. Every non-root node pushes into its own show-ahead FIFO. The
// root drives the registered output stage.
module merge_tree_param #(
    parameter int L           = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int KEY_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [L*DATA_WIDTH-1:0] i_fifo,
    input  logic [L-1:0]            i_fifo_empty,
    input  logic [L-1:0]            i_fifo_done,
    input  logic                    i_fifo_out_ready,
    output logic [L-1:0]            o_fifo_read,
    output logic                    o_out_fifo_write,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_done,
    output logic [COUNT_WIDTH-1:0]  o_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Output view of every non-root node and every leaf, as seen by its parent.
    // These depend only on registers and primary inputs.
    logic [DATA_WIDTH-1:0] head_s  [2:2*L-1];
    logic                  empty_s [2:2*L-1];
    logic                  done_s  [2:2*L-1];
    // Dequeue strobe issued by the parent of each node/leaf.
    logic                  deq_s   [2:2*L-1];

    // Per merge-node signals.
    logic                  fire_s    [1:L-1];
    logic [DATA_WIDTH-1:0] item_s    [1:L-1];
    logic                  space_s   [1:L-1];
    logic                  done_q_s  [1:L-1];

    // Leaves map straight onto the input ports.
    for (genvar k = 0; k < L; k++) begin : g_leaf
        assign head_s[L+k]    = i_fifo[DATA_WIDTH*k +: DATA_WIDTH];
        assign empty_s[L+k]   = i_fifo_empty[k];
        assign done_s[L+k]    = i_fifo_done[k];
        assign o_fifo_read[k] = deq_s[L+k];
    end

    // Two-input merge nodes.
    for (genvar n = 1; n < L; n++) begin : g_node
        logic sel_a_s;
        logic sel_b_s;
        logic a_fin_s;
        logic b_fin_s;
        logic a_le_b_s;
        logic done_q_r;

        // Choose which child to dequeue: smaller key, ties to the left child,
        // a finished child never blocks, an undone empty child always stalls.
        always_comb begin
            a_fin_s  = empty_s[2*n] & done_s[2*n];
            b_fin_s  = empty_s[2*n+1] & done_s[2*n+1];
            a_le_b_s = (head_s[2*n][KEY_WIDTH-1:0] <= head_s[2*n+1][KEY_WIDTH-1:0]);
            sel_a_s  = 1'b0;
            sel_b_s  = 1'b0;
            if (!empty_s[2*n] && !empty_s[2*n+1]) begin
                sel_a_s = a_le_b_s;
                sel_b_s = ~a_le_b_s;
            end else if (!empty_s[2*n] && b_fin_s) begin
                sel_a_s = 1'b1;
            end else if (a_fin_s && !empty_s[2*n+1]) begin
                sel_b_s = 1'b1;
            end else begin
                sel_a_s = 1'b0;
                sel_b_s = 1'b0;
            end
        end

        assign fire_s[n]     = space_s[n] & (sel_a_s | sel_b_s) & ~i_rst;
        assign deq_s[2*n]    = fire_s[n] & sel_a_s;
        assign deq_s[2*n+1]  = fire_s[n] & sel_b_s;
        assign item_s[n]     = sel_a_s ? head_s[2*n] : head_s[2*n+1];
        assign done_q_s[n]   = done_q_r;

        // Sticky node-finished flag: both children drained and finished.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                done_q_r <= 1'b0;
            end else if (a_fin_s && b_fin_s && !fire_s[n]) begin
                done_q_r <= 1'b1;
            end else begin
                done_q_r <= done_q_r;
            end
        end
    end

    // The root writes into the output register, gated by downstream readiness.
    assign space_s[1] = i_fifo_out_ready;

    // Show-ahead FIFO behind every non-root node. Full is taken from the
    // registered occupancy, so a pop frees a slot only on the next cycle.
    for (genvar n = 2; n < L; n++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
        logic [AW-1:0]         wr_ptr_r;
        logic [AW-1:0]         rd_ptr_r;
        logic [AW:0]           cnt_r;

        assign head_s[n]  = mem_r[rd_ptr_r];
        assign empty_s[n] = (cnt_r == (AW+1)'(0));
        assign space_s[n] = (cnt_r != (AW+1)'(FIFO_DEPTH));
        assign done_s[n]  = done_q_s[n] & empty_s[n];

        // Storage write, pointer and occupancy update.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                wr_ptr_r <= AW'(0);
                rd_ptr_r <= AW'(0);
                cnt_r    <= (AW+1)'(0);
            end else begin
                if (fire_s[n]) begin
                    mem_r[wr_ptr_r] <= item_s[n];
                    wr_ptr_r        <= wr_ptr_r + AW'(1);
                end
                if (deq_s[n]) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({fire_s[n], deq_s[n]})
                    2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                    2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end
    end

    logic                   out_write_r;
    logic [DATA_WIDTH-1:0]  data_r;
    logic                   done_r;
    logic [COUNT_WIDTH-1:0] count_r;

    // Output stage: capture the root's pick, count it, and flag full drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_write_r <= 1'b0;
            data_r      <= DATA_WIDTH'(0);
            done_r      <= 1'b0;
            count_r     <= COUNT_WIDTH'(0);
        end else begin
            out_write_r <= fire_s[1];
            if (fire_s[1]) begin
                data_r  <= item_s[1];
                count_r <= count_r + COUNT_WIDTH'(1);
            end else begin
                data_r  <= data_r;
                count_r <= count_r;
            end
            done_r <= done_r | (done_q_s[1] & ~out_write_r);
        end
    end

    assign o_out_fifo_write = out_write_r;
    assign o_data           = data_r;
    assign o_done           = done_r;
    assign o_count          = count_r;

endmodule

// File: tb/tb_merge_tree_param.sv
// Scoreboard bench for merge_tree_param: leaves are modelled as show-ahead
// queues, the expected output order is a stable sort of all loaded items.
module tb_merge_tree_param;

    localparam int L   = 8;
    localparam int DW  = 32;
    localparam int KW  = 16;
    localparam int FD  = 2;
    localparam int CW  = 32;
    localparam int LVL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [L*DW-1:0] fifo;
    logic [L-1:0]  fifo_empty;
    logic [L-1:0]  fifo_done;
    logic          out_ready;
    logic [L-1:0]  fifo_read;
    logic          out_write;
    logic [DW-1:0] data;
    logic          done;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    merge_tree_param #(
        .L(L), .DATA_WIDTH(DW), .KEY_WIDTH(KW), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_fifo(fifo),
        .i_fifo_empty(fifo_empty),
        .i_fifo_done(fifo_done),
        .i_fifo_out_ready(out_ready),
        .o_fifo_read(fifo_read),
        .o_out_fifo_write(out_write),
        .o_data(data),
        .o_done(done),
        .o_count(count)
    );

    logic [DW-1:0] leaf_q [L][$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] pend_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int first_rd = -1;
    int last_pulse = -1;
    int done_cyc = -1;
    logic rand_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sort_key(input logic [DW-1:0] d);
        return {d[KW-1:0], d[DW-1:KW]};
    endfunction

    task automatic drive_leaves();
        for (int k = 0; k < L; k++) begin
            fifo_empty[k] = (leaf_q[k].size() == 0);
            fifo[k*DW +: DW] = fifo_empty[k] ? '0 : leaf_q[k][0];
        end
    endtask

    // Upper half of the data is a tag (leaf*256 + position) for tie checking.
    task automatic add_item(input int k, input int key);
        logic [DW-1:0] d;
        d = {16'(k * 256 + leaf_q[k].size()), 16'(key)};
        leaf_q[k].push_back(d);
        pend_q.push_back(d);
    endtask

    task automatic commit_expected();
        logic [DW-1:0] a [$];
        logic [DW-1:0] t;
        a = pend_q;
        for (int i = 1; i < a.size(); i++) begin
            for (int j = i; j > 0; j--) begin
                if (sort_key(a[j-1]) > sort_key(a[j])) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
            end
        end
        foreach (a[i]) exp_q.push_back(a[i]);
        pend_q.delete();
    endtask

    task automatic tick();
        logic [L-1:0] rd;
        logic         rdy;
        int           c0;
        drive_leaves();
        @(negedge clk);
        rd  = fifo_read;
        rdy = out_ready;
        c0  = cyc;
        if (rst) check_eq("read_in_reset", rd, 0);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < L; k++) begin
            if (rd[k]) begin
                check_eq("read_of_empty_leaf", fifo_empty[k], 1'b0);
                if (leaf_q[k].size() > 0) void'(leaf_q[k].pop_front());
                if (k == 0 && first_rd < 0) first_rd = c0;
            end
        end
        if (out_write === 1'b1) begin
            pulses++;
            last_pulse = cyc;
            check_eq("ready_before_pulse", rdy, 1'b1);
            if (exp_q.size() > 0) check_eq("data", data, exp_q.pop_front());
            else check_eq("extra_item", exp_q.size(), 1);
        end
        if (done === 1'b1) begin
            if (done_cyc < 0) done_cyc = cyc;
            check_eq("done_early", exp_q.size(), 0);
        end
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        rand_ready = 1'b0;
        tick();
        check_eq("rst_count", count, 0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_write", out_write, 1'b0);
        check_eq("rst_data", data, 0);
        for (int k = 0; k < L; k++) leaf_q[k].delete();
        exp_q.delete();
        pend_q.delete();
        fifo_done = '0;
        pulses = 0;
        first_rd = -1;
        last_pulse = -1;
        done_cyc = -1;
        rst = 1'b0;
    endtask

    task automatic run_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && done === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, {exp_q.size() == 0, done === 1'b1}, 2'b11);
        check_eq({tag, "_done_latency"},
                 (done_cyc - last_pulse >= 1) && (done_cyc - last_pulse <= 2), 1'b1);
    endtask

    initial begin
        int key;
        int n;
        rst = 1'b1;
        out_ready = 1'b1;
        fifo_done = '0;
        fifo = '0;
        fifo_empty = '1;

        // Basic four-leaf merge.
        apply_reset();
        add_item(0, 1); add_item(0, 9);
        add_item(1, 2); add_item(1, 7);
        add_item(2, 3); add_item(2, 8);
        add_item(3, 4); add_item(3, 6);
        fifo_done = '1;
        commit_expected();
        run_drain("basic", 200);
        check_eq("basic_count", count, 8);

        // Single item latency through all levels.
        apply_reset();
        add_item(0, 5);
        fifo_done = '1;
        commit_expected();
        run_drain("latency", 100);
        check_eq("latency_cycles", last_pulse - first_rd, LVL);
        check_eq("latency_count", count, 1);

        // Equal keys resolve towards the lower leaf index.
        apply_reset();
        add_item(0, 5); add_item(0, 5);
        add_item(1, 5);
        fifo_done = '1;
        commit_expected();
        run_drain("ties", 100);
        check_eq("ties_count", count, 3);

        // An empty, unfinished sibling stalls the node.
        apply_reset();
        add_item(0, 3);
        fifo_done = 8'hFD;
        commit_expected();
        repeat (10) tick();
        check_eq("stall_no_read", first_rd, -1);
        check_eq("stall_no_output", pulses, 0);
        fifo_done = '1;
        run_drain("stall", 100);
        check_eq("stall_count", count, 1);

        // Random backpressure with shallow internal FIFOs.
        apply_reset();
        for (int k = 0; k < L; k++) begin
            key = $urandom_range(0, 20);
            for (int j = 0; j < 8; j++) begin
                key += $urandom_range(0, 3);
                add_item(k, key);
            end
        end
        fifo_done = '1;
        commit_expected();
        rand_ready = 1'b1;
        run_drain("backpressure", 3000);
        check_eq("backpressure_count", count, 64);
        rand_ready = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a run, then a fresh run.
        apply_reset();
        for (int k = 0; k < L; k++) begin
            for (int j = 0; j < 4; j++) add_item(k, j * 10 + k);
        end
        fifo_done = '1;
        commit_expected();
        n = 0;
        while (pulses < 10 && n < 300) begin
            tick();
            n++;
        end
        check_eq("midrun_pulses", pulses, 10);
        apply_reset();
        for (int k = 0; k < L; k++) begin
            add_item(k, 100 - k); add_item(k, 200 + k);
        end
        fifo_done = '1;
        commit_expected();
        run_drain("fresh", 300);
        check_eq("fresh_count", count, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
